// File: rtl/cpu_defs.sv
// cpu_defs: shared CPU constants and the instruction-memory legal-range check.
package cpu_defs;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
    localparam int          IM_WORDS_DEF = 4096;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;

    // Word-aligned and inside [base, base + 4*words); computed in 33 bits so the top bound cannot wrap.
    function automatic logic pc_legal(input logic [31:0] pc, input logic [31:0] base, input int words);
        logic [32:0] limit;
        limit = {1'b0, base} + (33'(words) << 2);
        return (pc[1:0] == 2'b00) && (pc >= base) && ({1'b0, pc} < limit);
    endfunction
endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register; flush beats stall beats capture, async active-low reset.
module if_id_reg
    import cpu_defs::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc_in,
    input  logic        fault_in,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc8_d,
    output logic        fault_d
);
    // A flush leaves pc_d/pc8_d alone so the bubble still carries the last real PC.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_d <= NOP_INSTR;
            pc_d    <= RESET_PC;
            pc8_d   <= RESET_PC + 32'd8;
            fault_d <= 1'b0;
        end else if (flush) begin
            instr_d <= NOP_INSTR;
            fault_d <= 1'b0;
        end else if (!stall) begin
            instr_d <= instr_in;
            pc_d    <= pc_in;
            pc8_d   <= pc_in + 32'd8;
            fault_d <= fault_in;
        end
    end
endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: MIPS fetch stage; PC register, next-PC select, fetch fault check and IF/ID capture.
module if_fetch_unit
    import cpu_defs::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          IM_WORDS = IM_WORDS_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    input  logic [31:0] instr_f,
    output logic [31:0] pc_f,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc8_d,
    output logic        fault_d
);
    logic [31:0] pc_next;
    logic        fault_f;

    assign fault_f = !pc_legal(pc_f, RESET_PC, IM_WORDS);

    // Redirect during stall is dropped; decode re-asserts it once it is released.
    always_comb pc_next = stall ? pc_f : redirect_en ? redirect_pc : pc_f + 32'd4;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pc_f <= RESET_PC;
        else        pc_f <= pc_next;
    end

    if_id_reg #(.RESET_PC(RESET_PC)) u_if_id (
        .clk      (clk),
        .reset    (reset),
        .stall    (stall),
        .flush    (flush),
        .instr_in (fault_f ? NOP_INSTR : instr_f),
        .pc_in    (pc_f),
        .fault_in (fault_f),
        .instr_d  (instr_d),
        .pc_d     (pc_d),
        .pc8_d    (pc8_d),
        .fault_d  (fault_d)
    );
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: scoreboard bench for the fetch stage against a reference model of the fetch rules.
module tb_if_fetch_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0, flush = 1'b0, redirect_en = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] instr_f, pc_f, instr_d, pc_d, pc8_d;
    logic        fault_d;
    logic [31:0] mem [4096];
    logic [31:0] im_off;

    typedef struct packed {
        logic [31:0] pc_f, instr_d, pc_d, pc8_d;
        logic        fault_d;
    } exp_t;
    exp_t exp_q[$];

    int tests = 0, fails = 0;
    logic [31:0] m_pc, m_instr, m_pcd, m_pc8;
    logic        m_fault;

    if_fetch_unit dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .redirect_en(redirect_en), .redirect_pc(redirect_pc), .instr_f(instr_f),
        .pc_f(pc_f), .instr_d(instr_d), .pc_d(pc_d), .pc8_d(pc8_d), .fault_d(fault_d)
    );

    always #5 clk = ~clk;

    // Instruction memory: garbage outside the window so any leak of fault data shows up.
    assign im_off = pc_f - 32'h3000;
    always_comb begin
        instr_f = 32'hBAD0_0BAD;
        if (pc_f >= 32'h3000 && pc_f < 32'h7000) instr_f = mem[im_off[13:2]];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] im_word(input logic [31:0] pc);
        logic [31:0] off;
        off = pc - 32'h3000;
        return mem[off[13:2]];
    endfunction

    function automatic logic model_fault(input logic [31:0] pc);
        return (pc % 4 != 0) || (pc < 32'h3000) || (pc >= 32'h3000 + 4 * 4096);
    endfunction

    task automatic model_reset();
        m_pc = 32'h3000; m_instr = 32'h0; m_pcd = 32'h3000; m_pc8 = 32'h3008; m_fault = 1'b0;
    endtask

    // Apply one cycle of inputs, advance the model, and queue what the DUT must show after the edge.
    task automatic drive(input logic s, input logic f, input logic r, input logic [31:0] rp);
        logic flt;
        stall = s; flush = f; redirect_en = r; redirect_pc = rp;
        flt = model_fault(m_pc);
        if (f) begin
            m_instr = 32'h0; m_fault = 1'b0;
        end else if (!s) begin
            m_instr = flt ? 32'h0 : im_word(m_pc);
            m_pcd = m_pc; m_pc8 = m_pc + 32'd8; m_fault = flt;
        end
        if (!s) m_pc = r ? rp : m_pc + 32'd4;
        @(posedge clk);
        exp_q.push_back('{m_pc, m_instr, m_pcd, m_pc8, m_fault});
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("sb_pc_f", pc_f, e.pc_f);
                check("sb_instr_d", instr_d, e.instr_d);
                check("sb_pc_d", pc_d, e.pc_d);
                check("sb_pc8_d", pc8_d, e.pc8_d);
                check("sb_fault_d", {31'h0, fault_d}, {31'h0, e.fault_d});
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [31:0] rp;
        for (int i = 0; i < 4096; i++) mem[i] = $urandom;
        model_reset();
        #12;
        check("rst_pc_f", pc_f, 32'h3000);
        check("rst_instr_d", instr_d, 32'h0);
        check("rst_pc_d", pc_d, 32'h3000);
        check("rst_pc8_d", pc8_d, 32'h3008);
        check("rst_fault_d", {31'h0, fault_d}, 32'h0);
        @(negedge clk); reset = 1'b1;
        drive(0, 0, 0, 0);
        check("seq_pc_f1", pc_f, 32'h3004);
        check("seq_instr1", instr_d, mem[0]);
        drive(0, 0, 0, 0);
        check("seq_pc_f2", pc_f, 32'h3008);
        drive(0, 0, 1, 32'h3100);
        check("redir_pc_f", pc_f, 32'h3100);
        check("redir_delay_slot", instr_d, mem[2]);
        check("redir_pc_d", pc_d, 32'h3008);
        drive(0, 0, 1, 32'h3010);
        drive(1, 0, 0, 0);
        drive(1, 0, 1, 32'h3200);
        drive(1, 0, 0, 0);
        check("stall_pc_f", pc_f, 32'h3010);
        check("stall_pc_d", pc_d, 32'h3100);
        check("stall_instr_d", instr_d, mem[32'h40]);
        drive(0, 0, 1, 32'h3004);
        drive(0, 0, 0, 0);
        drive(1, 1, 0, 0);
        check("sflush_instr_d", instr_d, 32'h0);
        check("sflush_pc_d", pc_d, 32'h3004);
        check("sflush_pc_f", pc_f, 32'h3008);
        drive(0, 0, 0, 0);
        check("post_flush_instr", instr_d, mem[2]);
        drive(0, 0, 1, 32'h3002);
        drive(0, 0, 0, 0);
        check("mis_fault_d", {31'h0, fault_d}, 32'h1);
        check("mis_instr_d", instr_d, 32'h0);
        check("mis_pc_d", pc_d, 32'h3002);
        check("mis_pc_f", pc_f, 32'h3006);
        drive(0, 0, 1, 32'h7000);
        drive(0, 0, 0, 0);
        check("oor_fault_d", {31'h0, fault_d}, 32'h1);
        check("oor_pc_d", pc_d, 32'h7000);
        check("oor_pc_f", pc_f, 32'h7004);
        drive(0, 0, 1, 32'h3040);
        @(negedge clk); #1;
        reset = 1'b0;
        #1;
        check("async_pc_f", pc_f, 32'h3000);
        check("async_instr_d", instr_d, 32'h0);
        check("async_pc8_d", pc8_d, 32'h3008);
        model_reset();
        @(negedge clk); reset = 1'b1;
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 19))
                0:       rp = $urandom;
                1, 2:    rp = 32'h3000 + ($urandom_range(0, 4095) << 2) + 32'($urandom_range(1, 3));
                default: rp = 32'h3000 + ($urandom_range(0, 4095) << 2);
            endcase
            drive($urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 6) == 0, rp);
        end
        stall = 1'b0; flush = 1'b0; redirect_en = 1'b0;
        for (int w = 0; w < 10 && exp_q.size() != 0; w++) @(posedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL sb_drain actual=%0d required=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
